// File: rtl/lfsr_gen.sv
// Runtime-configurable LFSR: Fibonacci or Galois stepping, parallel/serial seeding,
// all-zero lock-up recovery and a period counter referenced to the last seed.
module lfsr_gen #(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
   parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic             s_reg_in,
   input  logic             wr_en,
   input  logic             wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   output logic             lfsr_out,
   output logic [WIDTH-1:0] state,
   output logic             lockup,
   output logic             period_done,
   output logic [WIDTH-1:0] period,
   output logic             io_oeb
);

   localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] t_q, t_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             lockup_q, lockup_d;
   logic             done_q, done_d;

   logic             fb;
   logic [WIDTH-1:0] step_fib;
   logic [WIDTH-1:0] step_gal;
   logic [WIDTH-1:0] step_next;
   logic [WIDTH-1:0] shift_in;

   always_comb begin
      fb        = ^(s_q & t_q);
      step_fib  = {s_q[WIDTH-2:0], fb};
      step_gal  = {s_q[WIDTH-2:0], 1'b0} ^ (s_q[WIDTH-1] ? t_q : '0);
      step_next = mode ? step_gal : step_fib;
      shift_in  = {s_q[WIDTH-2:0], s_reg_in};
   end

   // Priority is wr_en > load > en; losing requests are dropped, not queued.
   always_comb begin
      s_d      = s_q;
      t_d      = t_q;
      seed_d   = seed_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      lockup_d = 1'b0;
      done_d   = 1'b0;
      if (wr_en) begin
         cnt_d = '0;
         if (wr_sel) begin
            t_d = wr_data;
         end else begin
            s_d    = wr_data;
            seed_d = wr_data;
         end
      end else if (load) begin
         s_d    = shift_in;
         seed_d = shift_in;
         cnt_d  = '0;
      end else if (en) begin
         if (s_q == '0) begin
            s_d      = SEED;
            seed_d   = SEED;
            cnt_d    = '0;
            lockup_d = 1'b1;
         end else begin
            s_d = step_next;
            if (step_next == seed_q) begin
               period_d = cnt_q + One;
               cnt_d    = '0;
               done_d   = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + One;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_q      <= SEED;
         t_q      <= TAPS;
         seed_q   <= SEED;
         cnt_q    <= '0;
         period_q <= '0;
         lockup_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         s_q      <= s_d;
         t_q      <= t_d;
         seed_q   <= seed_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         lockup_q <= lockup_d;
         done_q   <= done_d;
      end
   end

   assign state       = s_q;
   assign lfsr_out    = s_q[WIDTH-1];
   assign lockup      = lockup_q;
   assign period_done = done_q;
   assign period      = period_q;
   assign io_oeb      = 1'b0;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen (WIDTH=8, TAPS=B8, SEED=01): arithmetic reference model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_lfsr_gen;

   logic       clk;
   logic       reset;
   logic       en, mode, load, s_reg_in, wr_en, wr_sel;
   logic [7:0] wr_data;
   logic       lfsr_out, lockup, period_done, io_oeb;
   logic [7:0] state, period;

   int checks   = 0;
   int failures = 0;

   lfsr_gen #(
      .WIDTH(8),
      .TAPS (8'hB8),
      .SEED (8'h01)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .load       (load),
      .s_reg_in   (s_reg_in),
      .wr_en      (wr_en),
      .wr_sel     (wr_sel),
      .wr_data    (wr_data),
      .lfsr_out   (lfsr_out),
      .state      (state),
      .lockup     (lockup),
      .period_done(period_done),
      .period     (period),
      .io_oeb     (io_oeb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the step rules.
   int m_s, m_t, m_seed, m_cnt, m_period, m_lock, m_done;

   function automatic int next_val(input int s, input int t, input logic gal);
      int sh;
      sh = (s * 2) % 256;
      if (!gal) return sh + ($countones(s & t) % 2);
      return (s >= 128) ? (sh ^ t) : sh;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s      <= 1;
         m_t      <= 'hB8;
         m_seed   <= 1;
         m_cnt    <= 0;
         m_period <= 0;
         m_lock   <= 0;
         m_done   <= 0;
      end else begin
         m_lock <= 0;
         m_done <= 0;
         if (wr_en) begin
            m_cnt <= 0;
            if (wr_sel) m_t <= int'(wr_data);
            else begin
               m_s    <= int'(wr_data);
               m_seed <= int'(wr_data);
            end
         end else if (load) begin
            m_s    <= (m_s * 2 + int'(s_reg_in)) % 256;
            m_seed <= (m_s * 2 + int'(s_reg_in)) % 256;
            m_cnt  <= 0;
         end else if (en) begin
            if (m_s == 0) begin
               m_s    <= 1;
               m_seed <= 1;
               m_cnt  <= 0;
               m_lock <= 1;
            end else begin
               m_s <= next_val(m_s, m_t, mode);
               if (next_val(m_s, m_t, mode) == m_seed) begin
                  m_period <= m_cnt + 1;
                  m_cnt    <= 0;
                  m_done   <= 1;
               end else begin
                  m_cnt <= (m_cnt == 255) ? 255 : m_cnt + 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      check("model_state", int'(state), m_s);
      check("model_lfsr_out", int'(lfsr_out), (m_s >= 128) ? 1 : 0);
      check("model_lockup", int'(lockup), m_lock);
      check("model_period_done", int'(period_done), m_done);
      check("model_period", int'(period), m_period);
      check("model_io_oeb", int'(io_oeb), 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!period_done && n < max);
      check("period_done_seen", int'(period_done), 1);
   endtask

   logic [7:0] fib_exp [4];
   logic [7:0] ser_bits;
   int         n;

   initial begin
      fib_exp  = '{8'h02, 8'h04, 8'h08, 8'h11};
      ser_bits = 8'b1010_0101;
      en = 0; mode = 0; load = 0; s_reg_in = 0; wr_en = 0; wr_sel = 0; wr_data = '0;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", int'(state), 'h01);
      check("rst_period", int'(period), 0);
      check("rst_lockup", int'(lockup), 0);
      check("rst_done", int'(period_done), 0);
      check("rst_lfsr_out", int'(lfsr_out), 0);
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b1;

      // Fibonacci sequence from seed 01
      for (int i = 0; i < 4; i++) begin
         tick();
         check("fib_state", int'(state), int'(fib_exp[i]));
         check("fib_lfsr_out", int'(lfsr_out), 0);
      end

      // Full period: 255 steps total, then repeats every 255
      wait_done(300, n);
      check("period1_steps", n, 251);
      check("period1_len", int'(period), 255);
      check("period1_state", int'(state), 'h01);
      wait_done(300, n);
      check("period2_steps", n, 255);
      tick();
      check("done_one_cycle", int'(period_done), 0);

      // Reset on the cycle the next period_done would fire
      repeat (253) tick();
      reset = 1'b0;
      #1;
      check("midrst_state", int'(state), 'h01);
      check("midrst_period", int'(period), 0);
      check("midrst_done", int'(period_done), 0);
      check("midrst_lockup", int'(lockup), 0);
      tick();
      check("midrst_done_held", int'(period_done), 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("midrst_resume", int'(state), 'h02);

      // Lock-up recovery
      en = 0; wr_en = 1; wr_sel = 0; wr_data = 8'h00;
      tick();
      wr_en = 0; en = 1;
      check("zero_written", int'(state), 0);
      tick();
      check("lock_state", int'(state), 'h01);
      check("lock_pulse", int'(lockup), 1);
      tick();
      check("lock_clear", int'(lockup), 0);
      check("lock_step", int'(state), 'h02);
      en = 0; wr_en = 1; wr_data = 8'h00;
      tick();
      en = 1; wr_data = 8'h5A;
      tick();
      check("wr_beats_en", int'(state), 'h5A);
      check("wr_no_lock", int'(lockup), 0);

      // Galois step
      en = 0; wr_sel = 0; wr_data = 8'h80;
      tick();
      wr_sel = 1; wr_data = 8'h71;
      tick();
      wr_en = 0; en = 1; mode = 1;
      tick();
      en = 0;
      check("gal_state", int'(state), 'h71);
      check("gal_lfsr_out", int'(lfsr_out), 0);

      // Serial load with en held: load wins
      mode = 0; wr_en = 1; wr_sel = 1; wr_data = 8'hB8;
      tick();
      wr_en = 0; load = 1; en = 1;
      for (int i = 7; i >= 0; i--) begin
         s_reg_in = ser_bits[i];
         tick();
      end
      load = 0;
      check("serial_state", int'(state), 'hA5);
      wait_done(300, n);
      check("serial_period_steps", n, 255);
      check("serial_period_state", int'(state), 'hA5);
      check("serial_period_len", int'(period), 255);
      en = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised, runtime-configurable linear-feedback shift register. It generalises the fixed 8-bit, fixed-tap Fibonacci LFSR in the following ways:
- configurable width
- programmable tap mask
- selectable Fibonacci or Galois form
- parallel or serial seeding
- automatic lock-up recovery
- a hardware period counter

It sits in the user area as a pseudo-random source and self-test pattern generator, driven directly from IO or from a wishbone-facing wrapper.

## Interface

Parameters:
- WIDTH, 8, register width in bits; legal range 3..32.
- TAPS, 8'hB8, reset value of the tap mask (WIDTH bits).
- SEED, 8'h01, reset and lock-up reseed value (WIDTH bits); must be nonzero.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  advance the LFSR one step this cycle.
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled on each step.
- load  in  1  serial load: shift s_reg_in into the state LSB.
- s_reg_in  in  1  serial load data.
- wr_en  in  1  parallel write strobe.
- wr_sel  in  1  0 = write state, 1 = write tap mask.
- wr_data  in  WIDTH  parallel write data.
- lfsr_out  out  1  state[WIDTH-1].
- state  out  WIDTH  current LFSR state.
- lockup  out  1  one-cycle pulse on all-zero recovery.
- period_done  out  1  one-cycle pulse when the sequence returns to the seed.
- period  out  WIDTH  length of the last completed period.
- io_oeb  out  1  tied 0 (output enable for the pad).

## Operation

Internal registers:
- s: state, WIDTH bits
- t: tap mask, WIDTH bits
- seed_r: reference point for period detection, WIDTH bits
- cnt: step counter, WIDTH bits
- period_r: last completed period length
- the two pulse flags

Reset values (reset low, asynchronous):
- s = SEED, t = TAPS, seed_r = SEED
- cnt = 0, period = 0
- lockup = 0, period_done = 0
- lfsr_out = SEED[WIDTH-1], io_oeb = 0

Priority per cycle is wr_en > load > en; lower-priority requests in the same cycle are ignored, not queued.
- **Parallel write, state (wr_en, wr_sel=0):** s <= wr_data, seed_r <= wr_data, cnt <= 0.
- **Parallel write, taps (wr_en, wr_sel=1):** t <= wr_data, cnt <= 0, s unchanged.
- **Serial load (load):** s <= {s[WIDTH-2:0], s_reg_in}; seed_r <= that same new value; cnt <= 0. Taps are not applied.
- **Step, Fibonacci (en, mode=0):** fb = XOR-reduce(s & t); s <= {s[WIDTH-2:0], fb}.
- **Step, Galois (en, mode=1):** s <= {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? t : 0).
- **Lock-up:** if en is accepted while s == 0:
  - s <= SEED, seed_r <= SEED, cnt <= 0
  - lockup pulses for one cycle
  - no normal step is taken
- **Period detection:** on each normal step, if the next state equals seed_r:
  - period_r <= cnt + 1, cnt <= 0
  - period_done pulses for one cycle

  Otherwise cnt <= cnt + 1, saturating at all-ones; saturation never produces period_done. Non-maximal tap sets that never revisit seed_r therefore leave period unchanged.
- All-zero tap mask is legal:
  - Fibonacci shifts zeros in.
  - Galois shifts only.
  - Both reach s = 0, after which lock-up recovery applies.

## Timing

- All outputs are registered or driven directly from registers; there are no combinational input-to-output paths.
- Write, load and step effects are visible on state and lfsr_out the cycle after the triggering edge (latency 1).
- lockup and period_done are high for exactly the cycle following the triggering edge, then return to 0. A new trigger on the next edge holds them high for consecutive cycles.
- period updates in the same cycle that period_done is high.
- Reset asserted mid-operation forces all reset values immediately. This includes clearing any pulse in flight; a pending write is discarded.
- The first step is accepted on the first rising edge after reset deasserts.

## Test plan

- **Fibonacci step sequence:** reset (WIDTH=8, TAPS=B8, SEED=01), en=1, mode=0 -> state sequence 02, 04, 08, 11 on successive cycles; lfsr_out = 0 throughout.
- **Galois step:** wr state 80, wr taps 71, then one en with mode=1 -> state = 71 and lfsr_out = 0 the next cycle.
- **Full period:** from reset, hold en=1 (Fibonacci, B8) -> period_done pulses once after exactly 255 steps; period = 255; state = 01; the pulse repeats every 255 cycles.
- **Lock-up recovery:** write state 00, then en=1 -> next cycle state = 01, lockup = 1 for one cycle, cnt restarted; wr_en together with en in that cycle -> write wins, no lockup pulse.
- **Serial load and priority:**
  - load 8 bits 1,0,1,0,0,1,0,1 (en=1 held) -> state = A5, no steps taken.
  - Stepping then resumes, and period detection is referenced to A5.
- **Reset mid-operation:** assert reset during a run and on the cycle period_done would fire -> state = 01, period = 0, both pulses 0 immediately; normal stepping resumes from 01 after release.
